// File: rtl/ofm_pkg.sv
// Shared types and default sizing for the OFM write scheduler.
// Imported by the arbiter and the scheduler top.
package ofm_pkg;

    localparam int N_REQ_DEF  = 4;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant, pointer moves past the winner
// only when the grant is consumed (advance).
module rr_arbiter
    import ofm_pkg::*;
#(
    parameter int N = N_REQ_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] grant
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0]  ptr_q;
    logic [PW-1:0]  ptr_d;
    logic [PW-1:0]  off;
    logic [PW-1:0]  gidx;
    logic [PW:0]    sum;
    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic           found;

    // Rotate so the pointer lane sits at bit 0, then take the lowest set bit.
    always_comb begin
        dbl   = {req, req} >> ptr_q;
        rot   = dbl[N-1:0];
        found = 1'b0;
        off   = '0;
        for (int k = 0; k < N; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                off   = k[PW-1:0];
            end
        end
        sum = {1'b0, ptr_q} + {1'b0, off};
        if (sum >= (PW+1)'(N)) begin
            sum = sum - (PW+1)'(N);
        end
        gidx  = sum[PW-1:0];
        grant = found ? (N'(1) << gidx) : '0;
        ptr_d = ptr_q;
        if (advance && found) begin
            ptr_d = (gidx == PW'(N-1)) ? '0 : gidx + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/ofm_wr_sched.sv
// OFM write scheduler: arbitrates PE lanes onto one registered
// OFM write port for a tile of base_addr/tile_len words.
module ofm_wr_sched
    import ofm_pkg::*;
#(
    parameter int N_REQ  = N_REQ_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [ADDR_W-1:0]       tile_len,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    ofm_we,
    output logic [ADDR_W-1:0]       ofm_addr,
    output logic [DATA_W-1:0]       ofm_wdata,
    output logic                    busy,
    output logic                    done
);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]   cnt_q, cnt_d;
    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                done_q;

    logic                en;
    logic [N_REQ-1:0]    arb_req;
    logic [N_REQ-1:0]    grant;
    logic                xfer;
    logic [DATA_W-1:0]   gdata;

    // Grants only while words remain in the tile.
    assign en        = (state_q == RUN) && (cnt_q < len_q);
    assign arb_req   = req_valid & {N_REQ{en}};
    assign req_ready = grant;
    assign xfer      = |(req_valid & grant);

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .advance (xfer),
        .grant   (grant)
    );

    always_comb begin
        gdata = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                gdata = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    base_d  = base_addr;
                    len_d   = tile_len;
                    cnt_d   = '0;
                    state_d = (tile_len == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q + 1'b1 == len_q) begin
                        state_d = DONE;
                    end
                end else if (cnt_q >= len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
        end
    end

    // Write port lags the transfer by one cycle; address wraps naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
        end else begin
            we_q   <= xfer;
            done_q <= (state_q == DONE);
            if (xfer) begin
                addr_q  <= base_q + cnt_q;
                wdata_q <= gdata;
            end
        end
    end

    assign ofm_we    = we_q;
    assign ofm_addr  = addr_q;
    assign ofm_wdata = wdata_q;
    assign done      = done_q;
    assign busy      = (state_q == RUN);

endmodule

// File: tb/tb_ofm_wr_sched.sv
// Bench for ofm_wr_sched: tile-level reference model checked every
// cycle, plus hand-computed expectations for the directed tiles.
module tb_ofm_wr_sched;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int AW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic [AW-1:0]   base_addr = '0;
    logic [AW-1:0]   tile_len = '0;
    logic [N-1:0]    req_valid = '0;
    logic [N*DW-1:0] req_data = '0;
    logic [N-1:0]    req_ready;
    logic            ofm_we;
    logic [AW-1:0]   ofm_addr;
    logic [DW-1:0]   ofm_wdata;
    logic            busy;
    logic            done;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ofm_wr_sched #(
        .N_REQ  (N),
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .base_addr (base_addr),
        .tile_len  (tile_len),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .ofm_we    (ofm_we),
        .ofm_addr  (ofm_addr),
        .ofm_wdata (ofm_wdata),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Tile-level model state
    int cyc = 0;
    bit m_run = 1'b0;
    bit m_we = 1'b0;
    int m_base = 0, m_len = 0, m_cnt = 0, m_ptr = 0;
    int m_addr = 0, m_data = 0;
    int m_done_at = -10;

    // Observation logs of the DUT
    int wa[$];
    int wd[$];
    int wc[$];
    int gl[$];
    int done_cnt = 0;
    int done_cyc = -1;
    int start_cyc = -1;

    always @(negedge clk) begin : cmp
        logic [N-1:0]    er;
        logic [N-1:0]    vs;
        logic [N*DW-1:0] ds;
        int lane;
        int l;
        if (ofm_we) begin
            wa.push_back(int'(ofm_addr));
            wd.push_back(int'(ofm_wdata));
            wc.push_back(cyc);
        end
        for (int i = 0; i < N; i++) begin
            if (req_ready[i] && req_valid[i]) gl.push_back(i);
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (start) start_cyc = cyc;

        if (!rst_n) begin
            m_run = 1'b0; m_we = 1'b0; m_cnt = 0; m_ptr = 0;
            m_addr = 0; m_data = 0; m_done_at = -10;
            chk("rst_we", 32'(ofm_we), 32'd0);
            chk("rst_addr", 32'(ofm_addr), 32'd0);
            chk("rst_data", 32'(ofm_wdata), 32'd0);
            chk("rst_done", 32'(done), 32'd0);
            chk("rst_ready", 32'(req_ready), 32'd0);
        end else begin
            chk("we", 32'(ofm_we), 32'(m_we));
            if (m_we) begin
                chk("addr", 32'(ofm_addr), 32'(m_addr));
                chk("wdata", 32'(ofm_wdata), 32'(m_data));
            end
            chk("busy", 32'(busy), 32'(m_run));
            chk("done", 32'(done), 32'(cyc == m_done_at));
            er = '0;
            lane = -1;
            if (m_run && m_cnt < m_len) begin
                for (int k = 0; k < N; k++) begin
                    l = (m_ptr + k) % N;
                    vs = req_valid >> l;
                    if (lane < 0 && vs[0]) lane = l;
                end
            end
            if (lane >= 0) er = N'(1) << lane;
            chk("ready", 32'(req_ready), 32'(er));

            m_we = 1'b0;
            if (lane >= 0) begin
                ds = req_data >> (lane * DW);
                m_we = 1'b1;
                m_addr = (m_base + m_cnt) % (1 << AW);
                m_data = int'(ds[DW-1:0]);
                m_cnt++;
                m_ptr = (lane + 1) % N;
                if (m_cnt == m_len) begin
                    m_run = 1'b0;
                    m_done_at = cyc + 2;
                end
            end else if (start && !m_run && cyc != m_done_at - 1) begin
                m_base = int'(base_addr);
                m_len = int'(tile_len);
                m_cnt = 0;
                if (m_len == 0) m_done_at = cyc + 2;
                else m_run = 1'b1;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_logs();
        wa.delete(); wd.delete(); wc.delete(); gl.delete();
    endtask

    task automatic go(input int b, input int l);
        base_addr = AW'(b);
        tile_len = AW'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_done_seen"}, 32'(done_cnt - d0), 32'd1);
        repeat (2) tick();
    endtask

    task automatic chk_writes(input string nm, input int b, input int cnt);
        chk({nm, "_nwr"}, 32'(wa.size()), 32'(cnt));
        for (int i = 0; i < wa.size() && i < cnt; i++) begin
            chk({nm, "_wa"}, 32'(wa[i]), 32'((b + i) % (1 << AW)));
        end
    endtask

    initial begin
        int d0;
        int n;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Tile 1: all lanes, A0..A3
        clr_logs();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req_valid = 4'hF;
        go(32'h010, 4);
        wait_done("t1", 40);
        chk_writes("t1", 32'h010, 4);
        for (int i = 0; i < wd.size() && i < 4; i++) begin
            chk("t1_wd", 32'(wd[i]), 32'(8'hA0 + i));
            chk("t1_gl", 32'(gl[i]), 32'(i));
        end
        if (wc.size() == 4) chk("t1_done_cyc", 32'(done_cyc), 32'(wc[3] + 1));

        // Tile 2: lanes 1 and 3 only
        clr_logs();
        req_data = {8'h33, 8'h22, 8'h11, 8'h00};
        req_valid = 4'b1010;
        go(32'h100, 4);
        wait_done("t2", 40);
        chk("t2_ng", 32'(gl.size()), 32'd4);
        for (int i = 0; i < gl.size() && i < 4; i++) begin
            chk("t2_gl", 32'(gl[i]), (i % 2 == 0) ? 32'd1 : 32'd3);
        end

        // Tile 3: zero length
        clr_logs();
        req_valid = 4'hF;
        go(32'h055, 0);
        wait_done("t3", 20);
        chk("t3_done_cyc", 32'(done_cyc), 32'(start_cyc + 2));
        chk("t3_nwr", 32'(wa.size()), 32'd0);

        // Tile 4: address wrap
        clr_logs();
        req_data = {8'h44, 8'h43, 8'h42, 8'h41};
        go(32'h3FE, 4);
        wait_done("t4", 40);
        chk_writes("t4", 32'h3FE, 4);
        if (wa.size() == 4) chk("t4_wrap", 32'(wa[2]), 32'h000);

        // Tile 5: start during RUN is ignored
        clr_logs();
        req_valid = 4'h0;
        d0 = done_cnt;
        go(32'h040, 3);
        repeat (3) tick();
        go(32'h200, 7);
        req_valid = 4'b0101;
        tick();
        req_valid = 4'hF;
        wait_done("t5", 40);
        chk_writes("t5", 32'h040, 3);
        chk("t5_ndone", 32'(done_cnt - d0), 32'd1);

        // Tile 6: reset after two of five writes
        clr_logs();
        req_data = {8'h64, 8'h63, 8'h62, 8'h61};
        req_valid = 4'hF;
        go(32'h080, 5);
        n = 0;
        while (wa.size() < 2 && n < 30) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("t6_two_wr", 32'(wa.size()), 32'd2);
        d0 = done_cnt;
        rst_n = 1'b0;
        #1;
        chk("t6_we0", 32'(ofm_we), 32'd0);
        chk("t6_addr0", 32'(ofm_addr), 32'd0);
        chk("t6_data0", 32'(ofm_wdata), 32'd0);
        chk("t6_busy0", 32'(busy), 32'd0);
        chk("t6_ready0", 32'(req_ready), 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        repeat (3) tick();
        chk("t6_nodone", 32'(done_cnt - d0), 32'd0);
        clr_logs();
        go(32'h080, 5);
        wait_done("t6b", 40);
        chk_writes("t6b", 32'h080, 5);
        for (int i = 0; i < gl.size() && i < 5; i++) begin
            chk("t6b_gl", 32'(gl[i]), 32'(i % 4));
        end
        for (int i = 0; i < wd.size() && i < 5; i++) begin
            chk("t6b_wd", 32'(wd[i]), 32'(8'h61 + (i % 4)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
